deformat_data: RTL and testbench
================================

DEFORMAT_DATA -- requirements
Module: deformat_data

Interface
REQ-001 SHALL have parameter ITER, default 10, giving the number of reverse-double-dabble iterations (10 covers 3 BCD digits, 0..999).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  one-cycle request; sampled only while idle.
REQ-005 BCDIN  input  16  display word: [15:12] sign nibble (4'hA = positive, 4'hF = negative), [11:0] three BCD digits, hundreds in [11:8].
REQ-006 DOUT  output  10  sign-magnitude result: [9] sign (1 = negative), [8:0] magnitude.
REQ-007 DONE  output  1  one-cycle pulse; DOUT/ERR valid and updated on this cycle.
REQ-008 BUSY  output  1  high while a conversion is in progress.
REQ-009 ERR  output  1  error flag for the last conversion; held until the next DONE.

Function
REQ-010 SHALL implement FSM states IDLE, CONV, FINISH.
REQ-011 IDLE: START=1 at edge k SHALL capture BCDIN into a 12-bit shift register, capture the sign, latch the validity check, clear the iteration counter and enter CONV; BUSY=1 from edge k.
REQ-012 CONV: each edge SHALL shift {bcd_reg, bin_reg} right one bit, then subtract 3 from every BCD digit whose value is >= 8; edges k+1..k+ITER perform the ITER iterations, and CONV then exits to FINISH.
REQ-013 FINISH (edge k+ITER+1): SHALL load DOUT and ERR, pulse DONE for exactly one cycle, drop BUSY and return to IDLE.
REQ-014 Latency: DONE SHALL rise exactly ITER+1 cycles after the accepting edge (11 with the default ITER).
REQ-015 START while BUSY=1, including the FINISH cycle, SHALL be ignored; the earliest next accept is edge k+ITER+2.
REQ-016 BCDIN changes after edge k SHALL NOT affect the conversion in progress.
REQ-017 Validity: any digit > 9, or a sign nibble other than A or F, SHALL set ERR=1 and force DOUT=10'h000; the full latency still applies.
REQ-018 Sign: sign nibble F SHALL set DOUT[9]=1, including zero magnitude (F000 gives 10'h200).
REQ-019 Overflow: a binary value > 511 SHALL set ERR=1; the magnitude is handled per REQ-024.
REQ-020 A valid, in-range conversion SHALL clear ERR.
REQ-021 DOUT SHALL hold its value between DONE pulses.

Reset
REQ-022 RST low SHALL immediately force DOUT=0, DONE=0, BUSY=0, ERR=0, FSM=IDLE and clear the counter and shift registers, including mid-conversion; the aborted conversion produces no DONE.
REQ-023 After RST is released, the first START SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-024 Macro DEFORMAT_DATA_SAT_EN: when defined, overflow magnitude SHALL saturate to 9'h1FF; when undefined, magnitude SHALL be the binary value truncated to bits [8:0]; ERR=1 in both cases.

Verification
REQ-025 START with BCDIN=16'hA123 -> DONE 11 cycles later, DOUT=10'h07B, ERR=0, BUSY high for exactly 11 cycles.
REQ-026 BCDIN=16'hF511 -> DOUT=10'h3FF, ERR=0; then BCDIN=16'hF000 -> DOUT=10'h200, ERR=0.
REQ-027 BCDIN=16'hA999 -> with DEFORMAT_DATA_SAT_EN, DOUT=10'h1FF, ERR=1; without it, DOUT=10'h1E7, ERR=1.
REQ-028 BCDIN=16'hA1B2 -> DOUT=10'h000, ERR=1; BCDIN=16'h5123 -> DOUT=10'h000, ERR=1.
REQ-029 START held high continuously with BCDIN=16'hA042 -> accepts spaced exactly 12 cycles apart, each giving DOUT=10'h02A and one DONE pulse.
REQ-030 RST low at cycle 5 of a conversion -> all outputs 0 with no DONE; a new START for 16'hA007 then gives DOUT=10'h007 after 11 cycles.

Source files
------------

// File: rtl/deformat_data.sv
// rtl/deformat_data.sv - signed 3-digit BCD display word to sign-magnitude binary converter
//
// Purpose: converts a display word (sign nibble + three BCD digits) into a
// 10-bit sign-magnitude value with a reverse double-dabble engine that runs
// one iteration per clock.
//
// Ports:
//   CLK    in   1   clock, rising edge
//   RST    in   1   asynchronous active-low reset
//   START  in   1   conversion request, sampled only while idle
//   BCDIN  in  16   [15:12] sign nibble (A = +, F = -), [11:0] BCD hundreds/tens/ones
//   DOUT   out 10   [9] sign, [8:0] magnitude; held between DONE pulses
//   DONE   out  1   one-cycle pulse when DOUT/ERR update
//   BUSY   out  1   high while a conversion is in progress
//   ERR    out  1   invalid input or overflow for the last conversion
//
// Parameter ITER: number of reverse double-dabble iterations (>= 10).
// Optional macro DEFORMAT_DATA_SAT_EN: overflowing magnitudes saturate to
// 9'h1FF instead of being truncated to bits [8:0].

module deformat_data #(
  parameter int ITER = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] BCDIN,
  output logic [9:0]  DOUT,
  output logic        DONE,
  output logic        BUSY,
  output logic        ERR
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [ITER-1:0] bin_q, bin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            valid_q, valid_d;
  logic [9:0]      dout_q, dout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // One reverse double-dabble iteration: shift the combined register right,
  // then pull 3 from any digit that picked up a carried-in 8.
  logic [ITER+11:0] shifted;
  logic [11:0]      bcd_adj;

  assign shifted = {bcd_q, bin_q} >> 1;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_digit
      logic [3:0] dig;
      assign dig = shifted[ITER + 4*g +: 4];
      assign bcd_adj[4*g +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
    end
  endgenerate

  // Input validity is judged on the word captured at the accepting edge.
  logic in_valid;
  assign in_valid = ((BCDIN[15:12] == 4'hA) || (BCDIN[15:12] == 4'hF)) &&
                    (BCDIN[11:8] <= 4'd9) && (BCDIN[7:4] <= 4'd9) &&
                    (BCDIN[3:0] <= 4'd9);

  // Result formatting from the finished binary value.
  logic [31:0] bin_ext;
  logic        overflow;
  logic [8:0]  mag_ovf;

  assign bin_ext  = {{(32-ITER){1'b0}}, bin_q};
  assign overflow = (bin_ext > 32'd511);

`ifdef DEFORMAT_DATA_SAT_EN
  assign mag_ovf = 9'h1FF;
`else
  assign mag_ovf = bin_ext[8:0];
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          bcd_d   = BCDIN[11:0];
          bin_d   = '0;
          cnt_d   = '0;
          sign_d  = (BCDIN[15:12] == 4'hF);
          valid_d = in_valid;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_adj;
        bin_d = shifted[ITER-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!valid_q) begin
          dout_d = 10'h000;
          err_d  = 1'b1;
        end else if (overflow) begin
          dout_d = {sign_q, mag_ovf};
          err_d  = 1'b1;
        end else begin
          dout_d = {sign_q, bin_ext[8:0]};
          err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign DOUT = dout_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_deformat_data.sv
// tb/tb_deformat_data.sv - self-checking bench for deformat_data

module tb_deformat_data;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [15:0] BCDIN = 16'h0000;
  logic [9:0]  DOUT;
  logic        DONE;
  logic        BUSY;
  logic        ERR;

  int total = 0;
  int bad   = 0;

  deformat_data #(.ITER(10)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .BCDIN(BCDIN),
    .DOUT (DOUT),
    .DONE (DONE),
    .BUSY (BUSY),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] w;
    logic [9:0]  dout;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decimal value of the digits, then sign/overflow rules.
  function automatic logic [10:0] model(input logic [15:0] w);
    int d2, d1, d0, v;
    logic [3:0] s;
    logic [8:0] mag;
    s  = w[15:12];
    d2 = int'(w[11:8]);
    d1 = int'(w[7:4]);
    d0 = int'(w[3:0]);
    if (!(s == 4'hA || s == 4'hF) || d2 > 9 || d1 > 9 || d0 > 9)
      return {1'b1, 10'h000};
    v = d2 * 100 + d1 * 10 + d0;
    if (v > 511) begin
`ifdef DEFORMAT_DATA_SAT_EN
      mag = 9'h1FF;
`else
      mag = 9'(v % 512);
`endif
      return {1'b1, (s == 4'hF), mag};
    end
    mag = 9'(v);
    return {1'b0, (s == 4'hF), mag};
  endfunction

  task automatic do_conv(input logic [15:0] w, input logic [9:0] ed, input logic ee,
                         input string nm);
    int cyc, busy_n;
    bit got;
    @(negedge CLK);
    BCDIN = w;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START  = 1'b0;
    BCDIN  = 16'($urandom);
    busy_n = BUSY ? 1 : 0;
    cyc    = 0;
    got    = 0;
    while (!got && cyc < 30) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (DONE) got = 1;
      else if (BUSY) busy_n++;
    end
    chk({nm, " latency"}, cyc, 11);
    if (got) begin
      chk({nm, " dout"}, DOUT, ed);
      chk({nm, " err"}, ERR, ee);
      chk({nm, " busy_cycles"}, busy_n, 11);
      chk({nm, " busy_at_done"}, BUSY, 0);
      @(posedge CLK);
      #1;
      chk({nm, " done_pulse"}, DONE, 0);
      chk({nm, " dout_hold"}, DOUT, ed);
    end
  endtask

  vec_t vecs[12];

  initial begin
    int pos[$];
    logic [15:0] w;
    logic [10:0] m;

    vecs[0]  = '{16'hA123, 10'h07B, 1'b0};
    vecs[1]  = '{16'hF511, 10'h3FF, 1'b0};
    vecs[2]  = '{16'hF000, 10'h200, 1'b0};
`ifdef DEFORMAT_DATA_SAT_EN
    vecs[3]  = '{16'hA999, 10'h1FF, 1'b1};
    vecs[8]  = '{16'hA512, 10'h1FF, 1'b1};
    vecs[9]  = '{16'hF512, 10'h3FF, 1'b1};
`else
    vecs[3]  = '{16'hA999, 10'h1E7, 1'b1};
    vecs[8]  = '{16'hA512, 10'h000, 1'b1};
    vecs[9]  = '{16'hF512, 10'h200, 1'b1};
`endif
    vecs[4]  = '{16'hA1B2, 10'h000, 1'b1};
    vecs[5]  = '{16'h5123, 10'h000, 1'b1};
    vecs[6]  = '{16'hA000, 10'h000, 1'b0};
    vecs[7]  = '{16'hA511, 10'h1FF, 1'b0};
    vecs[10] = '{16'hFA00, 10'h000, 1'b1};
    vecs[11] = '{16'hA007, 10'h007, 1'b0};

    // Reset state
    #12;
    chk("rst dout", DOUT, 0);
    chk("rst done", DONE, 0);
    chk("rst busy", BUSY, 0);
    chk("rst err", ERR, 0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) do_conv(vecs[i].w, vecs[i].dout, vecs[i].err, $sformatf("vec%0d", i));

    // START held high: accepts every 12 cycles
    @(negedge CLK);
    BCDIN = 16'hA042;
    START = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        pos.push_back(i);
        chk("held dout", DOUT, 10'h02A);
      end
    end
    START = 1'b0;
    chk("held done_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("held first", pos[0], 11);
      chk("held gap1", pos[1] - pos[0], 12);
      chk("held gap2", pos[2] - pos[1], 12);
    end
    repeat (14) @(posedge CLK);

    // Reset in the middle of a conversion
    do_conv(16'hF511, 10'h3FF, 1'b0, "pre_rst");
    @(negedge CLK);
    BCDIN = 16'hA123;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("midrst dout", DOUT, 0);
    chk("midrst done", DONE, 0);
    chk("midrst busy", BUSY, 0);
    chk("midrst err", ERR, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 15; i++) begin
        @(posedge CLK);
        #1;
        if (DONE || BUSY) dn++;
      end
      chk("midrst no_done", dn, 0);
    end
    do_conv(16'hA007, 10'h007, 1'b0, "post_rst");

    // Randomized against reference model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: w[15:12] = 4'($urandom);
        1: w[15:12] = 4'hF;
        default: w[15:12] = 4'hA;
      endcase
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 7) == 0) w[4*d +: 4] = 4'($urandom);
        else w[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      m = model(w);
      do_conv(w, m[9:0], m[10], $sformatf("rnd%0d_%h", n, w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
